// File: rtl/systolic_skew_feeder.sv
// Edge driver for an N x N systolic MAC array: buffers A columns and B rows,
// then streams them diagonally skewed onto the west and north array edges.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int K  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col_in,
  input  logic [N*DW-1:0] b_row_in,
  input  logic            start,
  output logic [N*DW-1:0] west_out,
  output logic [N*DW-1:0] north_out,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(K + N) + 1;

  typedef enum logic [2:0] {LOAD, READY, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     load_cnt;
  logic [CW-1:0]     t;
  logic [K*N*DW-1:0] a_buf;
  logic [K*N*DW-1:0] b_buf;
  logic [N*DW-1:0]   west_nxt;
  logic [N*DW-1:0]   north_nxt;

  // Buffer holds beat k at [k*N*DW +: N*DW]; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready) begin
      a_buf[32'(load_cnt)*N*DW +: N*DW] <= a_col_in;
      b_buf[32'(load_cnt)*N*DW +: N*DW] <= b_row_in;
    end
  end

  // Lane i carries operand k = t - i; lanes outside the diagonal stay zero.
  always_comb begin
    west_nxt  = '0;
    north_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < K; k++) begin
        if (32'(t) == i + k) begin
          west_nxt[i*DW +: DW]  = a_buf[(k*N + i)*DW +: DW];
          north_nxt[i*DW +: DW] = b_buf[(k*N + i)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      load_cnt  <= '0;
      t         <= '0;
      west_out  <= '0;
      north_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      done      <= 1'b0;
      west_out  <= '0;
      north_out <= '0;
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            load_cnt <= load_cnt + CW'(1);
            if (load_cnt == CW'(K - 1)) begin
              state    <= READY;
              in_ready <= 1'b0;
            end
          end
        end
        READY: begin
          if (start) begin
            state <= STREAM;
            t     <= '0;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          west_out  <= west_nxt;
          north_out <= north_nxt;
          if (t == CW'(K + N - 2)) begin
            state <= DRAIN;
            t     <= '0;
          end else begin
            t <= t + CW'(1);
          end
        end
        DRAIN: begin
          if (t == CW'(N - 1)) begin
            state <= DONE;
            t     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            t <= t + CW'(1);
          end
        end
        DONE: begin
          state    <= LOAD;
          load_cnt <= '0;
          in_ready <= 1'b1;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: skew/timing model plus a behavioural PE array.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int K0 = 4;
  localparam int K1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            v0, s0, rdy0, busy0, done0;
  logic [N*DW-1:0] a0, b0, w0, n0;
  logic            v1, s1, rdy1, busy1, done1;
  logic [N*DW-1:0] a1, b1, w1, n1;

  int checks = 0;
  int failures = 0;

  logic [31:0] A [N][K0];
  logic [31:0] B [K0][N];

  logic        pe_clr;
  logic [31:0] acc  [N][N];
  logic [31:0] pe_w [N][N];
  logic [31:0] pe_n [N][N];

  systolic_skew_feeder #(.N(N), .DW(DW), .K(K0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
    .a_col_in(a0), .b_row_in(b0), .start(s0),
    .west_out(w0), .north_out(n0), .busy(busy0), .done(done0)
  );

  systolic_skew_feeder #(.N(N), .DW(DW), .K(K1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .a_col_in(a1), .b_row_in(b1), .start(s1),
    .west_out(w1), .north_out(n1), .busy(busy1), .done(done1)
  );

  function automatic logic [31:0] lane(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [31:0] win(input int i, input int j);
    return (j == 0) ? lane(w0, i) : pe_w[i][(j == 0) ? 0 : j-1];
  endfunction

  function automatic logic [31:0] nin(input int i, input int j);
    return (i == 0) ? lane(n0, j) : pe_n[(i == 0) ? 0 : i-1][j];
  endfunction

  // Reference 4x4 MAC array hung off dut0's edges.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (pe_clr) begin
          acc[i][j]  <= '0;
          pe_w[i][j] <= '0;
          pe_n[i][j] <= '0;
        end else begin
          acc[i][j]  <= acc[i][j] + win(i, j) * nin(i, j);
          pe_w[i][j] <= win(i, j);
          pe_n[i][j] <= nin(i, j);
        end
      end
    end
  end

  // After edge E0+c the edges show operands for t = c-1.
  function automatic logic [31:0] exp_w(input int i, input int c, input int kv);
    int tt;
    tt = c - 1;
    if (c >= 1 && tt >= i && tt - i < kv) return A[i][tt-i];
    return '0;
  endfunction

  function automatic logic [31:0] exp_n(input int j, input int c, input int kv);
    int tt;
    tt = c - 1;
    if (c >= 1 && tt >= j && tt - j < kv) return B[tt-j][j];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int which, input int kv);
    logic [N*DW-1:0] av, bv;
    for (int k = 0; k < kv; k++) begin
      for (int i = 0; i < N; i++) begin
        av[i*DW +: DW] = A[i][k];
        bv[i*DW +: DW] = B[k][i];
      end
      if (which == 0) begin v0 = 1'b1; a0 = av; b0 = bv; end
      else            begin v1 = 1'b1; a1 = av; b1 = bv; end
      step();
      chk($sformatf("load_ready k%0d", k), 32'((which == 0) ? rdy0 : rdy1), 32'(k < kv - 1));
    end
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic run_stream(input int which, input int kv, input bit do_pe);
    logic [31:0] sum;
    if (do_pe) begin pe_clr = 1'b1; step(); pe_clr = 1'b0; end
    if (which == 0) s0 = 1'b1; else s1 = 1'b1;
    step();
    s0 = 1'b0;
    s1 = 1'b0;
    for (int c = 0; c <= kv + 2*N; c++) begin
      if (c > 0) step();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("west c%0d l%0d", c, i), lane((which == 0) ? w0 : w1, i), exp_w(i, c, kv));
        chk($sformatf("north c%0d l%0d", c, i), lane((which == 0) ? n0 : n1, i), exp_n(i, c, kv));
      end
      chk($sformatf("busy c%0d", c), 32'((which == 0) ? busy0 : busy1), 32'(c <= kv + 2*N - 2));
      chk($sformatf("done c%0d", c), 32'((which == 0) ? done0 : done1), 32'(c == kv + 2*N - 1));
      chk($sformatf("ready c%0d", c), 32'((which == 0) ? rdy0 : rdy1), 32'(c == kv + 2*N));
      if (do_pe && c == kv + 2*N - 1) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            sum = '0;
            for (int k = 0; k < kv; k++) sum = sum + A[i][k] * B[k][j];
            chk($sformatf("pe(%0d,%0d)", i, j), acc[i][j], sum);
          end
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K0; k++) begin
        A[i][k] = $urandom;
        B[k][i] = $urandom;
      end
  endtask

  initial begin
    rst = 1'b0;
    v0 = 1'b0; s0 = 1'b0; a0 = '0; b0 = '0;
    v1 = 1'b0; s1 = 1'b0; a1 = '0; b1 = '0;
    pe_clr = 1'b1;
    step();
    step();
    chk("rst west", w0[31:0] | w0[63:32] | w0[95:64] | w0[127:96], 32'd0);
    chk("rst north", n0[31:0] | n0[63:32] | n0[95:64] | n0[127:96], 32'd0);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst ready", 32'(rdy0), 32'd1);
    chk("rst ready1", 32'(rdy1), 32'd1);
    rst = 1'b1;
    pe_clr = 1'b0;
    step();

    // Five valid beats, start alongside beat 3: fifth beat must be dropped.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        a0[i*DW +: DW] = 32'(k + 1);
        b0[i*DW +: DW] = 32'(10 * (k + 1));
      end
      v0 = 1'b1;
      s0 = (k == 3);
      step();
      chk($sformatf("seq ready b%0d", k), 32'(rdy0), 32'(k < 3));
      chk($sformatf("seq busy b%0d", k), 32'(busy0), 32'd0);
    end
    v0 = 1'b0;
    s0 = 1'b0;
    step();
    chk("seq idle busy", 32'(busy0), 32'd0);
    chk("seq idle ready", 32'(rdy0), 32'd0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K0; k++) begin
        A[i][k] = 32'(k + 1);
        B[k][i] = 32'(10 * (k + 1));
      end
    run_stream(0, K0, 1'b1);

    // Skew pattern.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K0; k++) begin
        A[i][k] = 32'(16*i + k);
        B[k][i] = 32'(100 + 4*k + i);
      end
    load(0, K0);
    run_stream(0, K0, 1'b1);

    // Reset in the middle of streaming, then replay the same pattern.
    load(0, K0);
    s0 = 1'b1;
    step();
    s0 = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("midrst west", w0[31:0] | w0[63:32] | w0[95:64] | w0[127:96], 32'd0);
    chk("midrst north", n0[31:0] | n0[63:32] | n0[95:64] | n0[127:96], 32'd0);
    chk("midrst busy", 32'(busy0), 32'd0);
    chk("midrst ready", 32'(rdy0), 32'd1);
    step();
    rst = 1'b1;
    step();
    load(0, K0);
    run_stream(0, K0, 1'b1);

    // Identity A against B[k][j] = 4k+j+1.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K0; k++) begin
        A[i][k] = 32'(i == k);
        B[k][i] = 32'(4*k + i + 1);
      end
    load(0, K0);
    run_stream(0, K0, 1'b1);

    // All-twos A.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K0; k++) A[i][k] = 32'd2;
    load(0, K0);
    run_stream(0, K0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      load(0, K0);
      run_stream(0, K0, 1'b1);
    end

    // K != N instance.
    for (int r = 0; r < 2; r++) begin
      fill_random();
      load(1, K1);
      run_stream(1, K1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
